// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline stage family.
//   pipe_state_e  occupancy state of a two-entry stall/flush stage
//   state_count() maps a state to its occupancy (0..2). Illegal encodings map to 0.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,  // no word held
        BUSY  = 2'b01,  // head register valid
        FULL  = 2'b10   // head and skid registers valid
    } pipe_state_e;

    function automatic logic [1:0] state_count(input pipe_state_e st);
        logic [1:0] cnt;
        cnt = 2'd0;
        case (st)
            BUSY:    cnt = 2'd1;
            FULL:    cnt = 2'd2;
            default: cnt = 2'd0;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry pipeline register with a skid buffer.
// It gives full throughput (one word per cycle) while keeping every output
// registered. in_ready, out_valid and count decode only from state_q. That
// breaks the combinational ready path between upstream and downstream.
//
// Handshake: a word moves when valid && ready are both high at a rising clk
// edge. A producer holding valid keeps its data stable until ready. The
// consumer sees out_data held constant while out_valid && !out_ready.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   flush      synchronous clear, overrides all transfers
//   in_valid   upstream word present
//   in_ready   stage accepts a word this cycle
//   in_data    upstream payload [WIDTH-1:0]
//   out_valid  out_data holds a valid word
//   out_ready  downstream accepts this cycle
//   out_data   head payload, straight from the head register
//   count      occupancy 0..2
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    pipe_state_e      state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    logic in_xfer;
    logic out_xfer;

    // Outputs are decoded from registered state only.
    // An illegal encoding reports neither ready nor valid.
    always_comb begin
        in_ready  = (state_q == EMPTY) || (state_q == BUSY);
        out_valid = (state_q == BUSY)  || (state_q == FULL);
        count     = state_count(state_q);
        out_data  = head_q;
    end

    assign in_xfer  = in_valid  && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            // A same-cycle output transfer still counts as consumed. A
            // same-cycle input transfer is dropped.
            state_d = EMPTY;
            head_d  = RST_VAL;
            skid_d  = RST_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d = BUSY;
                        head_d  = in_data;
                    end
                end
                BUSY: begin
                    if (in_xfer && out_xfer) begin
                        head_d = in_data;
                    end else if (in_xfer) begin
                        // Downstream stalled: park the new word behind the head.
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low, so only the drain can happen here.
                    if (out_xfer) begin
                        state_d = BUSY;
                        head_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            head_q  <= RST_VAL;
            skid_q  <= RST_VAL;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   count;

    int n_vec;
    int n_err;

    logic [W-1:0] exp_q[$];

    pipe_skid_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_stage(input string tag, input logic rdy, input logic vld,
                               input logic [1:0] cnt);
        check_val({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, rdy});
        check_val({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, vld});
        check_val({tag, ".count"},     {30'd0, count},     {30'd0, cnt});
    endtask

    // ---------------- drivers ----------------
    // Advance one clock edge. Leave 1 time unit so registered outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    // ---------------- random phase ----------------
    task automatic random_phase(input int cycles);
        int  cnt_m;
        logic iv, ordy, fl, in_x, out_x;
        logic [W-1:0] d;
        exp_q.delete();
        cnt_m = 0;
        for (int c = 0; c < cycles; c++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 63) == 0);
            d    = $urandom;
            // Drive the opposite out_ready first, then the real one. in_ready
            // must match the model under both values.
            drive(iv, d, ~ordy, fl);
            #1;
            check_val("rnd.in_ready_vs_opp_ordy", {31'd0, in_ready}, {31'd0, (cnt_m < 2)});
            out_ready = ordy;
            #1;
            check_val("rnd.in_ready",  {31'd0, in_ready},  {31'd0, (cnt_m < 2)});
            check_val("rnd.out_valid", {31'd0, out_valid}, {31'd0, (cnt_m > 0)});
            check_val("rnd.count",     {30'd0, count},     cnt_m[W-1:0]);
            if (cnt_m > 0) check_val("rnd.out_data", out_data, exp_q[0]);
            in_x  = iv && (cnt_m < 2);
            out_x = ordy && (cnt_m > 0);
            if (fl) begin
                exp_q.delete();
            end else begin
                if (out_x) void'(exp_q.pop_front());
                if (in_x)  exp_q.push_back(d);
            end
            cnt_m = exp_q.size();
            step();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);

        // Reset held low
        repeat (2) @(posedge clk);
        #1;
        check_stage("rst_hold", 1'b1, 1'b0, 2'd0);
        check_val("rst_hold.out_data", out_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_stage("rst_rel", 1'b1, 1'b0, 2'd0);
        check_val("rst_rel.out_data", out_data, 32'h0);

        // Streaming 1,2,3 at full rate (first transfer on first edge after release)
        drive(1'b1, 32'h1, 1'b1, 1'b0);
        step();
        check_stage("stream1", 1'b1, 1'b1, 2'd1);
        check_val("stream1.data", out_data, 32'h1);
        in_data = 32'h2;
        step();
        check_stage("stream2", 1'b1, 1'b1, 2'd1);
        check_val("stream2.data", out_data, 32'h2);
        in_data = 32'h3;
        step();
        check_stage("stream3", 1'b1, 1'b1, 2'd1);
        check_val("stream3.data", out_data, 32'h3);
        in_valid = 1'b0;
        step();
        check_stage("stream_drain", 1'b1, 1'b0, 2'd0);

        // Backpressure: A then B with out_ready low
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        step();
        check_stage("bp_a", 1'b1, 1'b1, 2'd1);
        check_val("bp_a.data", out_data, 32'hA);
        in_data = 32'hB;
        step();
        check_stage("bp_full", 1'b0, 1'b1, 2'd2);
        check_val("bp_full.data", out_data, 32'hA);
        // in_ready is low, so this word must be ignored
        in_data = 32'hEE;
        step();
        check_stage("bp_stall", 1'b0, 1'b1, 2'd2);
        check_val("bp_stall.data", out_data, 32'hA);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        check_stage("bp_drain1", 1'b1, 1'b1, 2'd1);
        check_val("bp_drain1.data", out_data, 32'hB);
        step();
        check_stage("bp_drain2", 1'b1, 1'b0, 2'd0);

        // Flush in FULL with a same-cycle input of 0xC
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        step();
        in_data = 32'h22;
        step();
        check_stage("fl_pre", 1'b0, 1'b1, 2'd2);
        drive(1'b1, 32'hC, 1'b0, 1'b1);
        step();
        check_stage("fl_post", 1'b1, 1'b0, 2'd0);
        check_val("fl_post.data", out_data, 32'h0);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        check_stage("fl_after", 1'b1, 1'b0, 2'd0);
        check_val("fl_after.data", out_data, 32'h0);

        // Flush in BUSY with a same-cycle output transfer
        drive(1'b1, 32'h33, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h44, 1'b1, 1'b1);
        step();
        check_stage("fl_busy", 1'b1, 1'b0, 2'd0);
        check_val("fl_busy.data", out_data, 32'h0);
        drive(1'b0, '0, 1'b1, 1'b0);

        // Async reset mid-stream while BUSY holding 0x55
        drive(1'b1, 32'h55, 1'b0, 1'b0);
        step();
        check_stage("ar_busy", 1'b1, 1'b1, 2'd1);
        check_val("ar_busy.data", out_data, 32'h55);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_stage("ar_async", 1'b1, 1'b0, 2'd0);
        check_val("ar_async.data", out_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 32'h66, 1'b1, 1'b0);
        step();
        check_stage("ar_first", 1'b1, 1'b1, 2'd1);
        check_val("ar_first.data", out_data, 32'h66);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        check_stage("ar_drain", 1'b1, 1'b0, 2'd0);

        // Random scoreboard run
        random_phase(10000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (legal 1..1024).
REQ-002 SHALL have parameter RST_VAL, default {WIDTH{1'b0}}, value loaded into the data registers on reset and flush.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  synchronous clear; empties the stage.
REQ-006 in_valid  input  1  upstream presents a word.
REQ-007 in_ready  output  1  stage can accept a word this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  out_data holds a valid word.
REQ-010 out_ready  input  1  downstream accepts this cycle.
REQ-011 out_data  output  WIDTH  head payload, driven directly from a register.
REQ-012 count  output  2  occupancy, 0..2.

Function
REQ-013 Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-014 States SHALL be EMPTY (count 0), BUSY (count 1, head register valid), FULL (count 2, head and skid registers valid).
REQ-015 in_ready, out_valid and count SHALL be decoded from registered state only; there SHALL be no combinational path from out_ready or in_valid to any output.
REQ-016 in_ready = 1 in EMPTY and BUSY, 0 in FULL. out_valid = 1 in BUSY and FULL.
REQ-017 EMPTY + input transfer -> BUSY; head <= in_data. Latency from input to output is 1 cycle.
REQ-018 BUSY + input and output transfers in the same cycle -> stays BUSY; head <= in_data. This gives full throughput of 1 word/cycle.
REQ-019 BUSY + input transfer only -> FULL; skid <= in_data; head is unchanged.
REQ-020 BUSY + output transfer only -> EMPTY.
REQ-021 FULL + output transfer -> BUSY; head <= skid. in_valid is ignored because in_ready is 0.
REQ-022 Any state with no transfer SHALL hold state; out_data SHALL stay stable while out_valid && !out_ready.
REQ-023 The head and skid registers SHALL load only on the events above; they SHALL NOT toggle otherwise.
REQ-024 Words SHALL leave the stage in arrival order, with no loss and no duplication.
REQ-025 flush SHALL take priority over every transfer: next state is EMPTY and head/skid <= RST_VAL.
REQ-026 On flush, a same-cycle input transfer SHALL be discarded, and a same-cycle output transfer SHALL still count as consumed by downstream.
REQ-027 After flush, in_ready = 1 on the next cycle.
REQ-028 The state SHALL never exceed FULL.
REQ-029 Illegal state encodings SHALL recover to EMPTY on the next edge.

Reset
REQ-030 While rst = 0: state EMPTY, in_ready = 1, out_valid = 0, count = 0, out_data = RST_VAL, skid = RST_VAL.
REQ-031 Reset asserted mid-operation SHALL drop all held words immediately (asynchronously).
REQ-032 The first transfer is possible on the first rising clk edge after rst deasserts.

Structure
REQ-033 The state enum typedef (EMPTY/BUSY/FULL) SHALL live in shared package pipe_pkg, for reuse by other pipeline stages.
REQ-034 The block SHALL be flat, with no sub-modules: one state register, a head register and a skid register.
REQ-035 The block SHALL drop in wherever a stall/flush pipeline register sits. Stall maps to !out_ready; flush maps to flush.

Verification
REQ-036 Reset: hold rst = 0, then release with in_valid = 0 -> in_ready = 1, out_valid = 0, count = 0, out_data = 0.
REQ-037 Streaming: out_ready = 1, drive 0x1,0x2,0x3 on consecutive cycles -> out_data = 0x1,0x2,0x3 on the following consecutive cycles, with in_ready = 1 throughout.
REQ-038 Backpressure: out_ready = 0, send 0xA then 0xB -> count = 2 and in_ready = 0. Then raise out_ready -> 0xA then 0xB appear in order, and out_data stays stable while stalled.
REQ-039 Flush with simultaneous input: in FULL, assert flush with in_valid = 1 and in_data = 0xC -> next cycle count = 0, out_valid = 0, out_data = 0; 0xC is never output.
REQ-040 Async reset mid-stream: in BUSY holding 0x55, pull rst low between clock edges -> out_valid = 0 without waiting for a clock edge.
REQ-041 Random test: random in_valid/out_ready over 10k cycles against a scoreboard queue -> order preserved, no loss or duplication, count matches the model, and in_ready never depends on same-cycle out_ready.
